// File: rtl/grid_cell_painter_pkg.sv
// Shared geometry defaults, field widths and FSM encoding for the grid cell painter.
package grid_cell_painter_pkg;

  localparam int unsigned GRID_N_DEF  = 64;
  localparam int unsigned CELL_PX_DEF = 7;
  localparam int unsigned X0_DEF      = 96;
  localparam int unsigned Y0_DEF      = 16;
  localparam int unsigned FB_W_DEF    = 640;

  localparam int unsigned COL_W   = 6;
  localparam int unsigned ROW_W   = 10;
  localparam int unsigned COLOR_W = 8;
  localparam int unsigned ADDR_W  = 19;
  localparam int unsigned CNT_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_PAINT,
    ST_ACK,
    ST_RELEASE
  } state_t;

endpackage

// File: rtl/grid_cell_painter_prio.sv
// Lowest-index-wins encoder for the per-column request vector.
module onehot_priority_enc
  import grid_cell_painter_pkg::*;
#(
  parameter int unsigned N = GRID_N_DEF
) (
  input  logic [N-1:0]     req,
  output logic [COL_W-1:0] index,
  output logic             valid
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        index = COL_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/grid_cell_painter.sv
// Paints one CELL_PX x CELL_PX grid cell into the framebuffer per column request,
// then handshakes the acknowledge back to the requesting column.
module grid_cell_painter
  import grid_cell_painter_pkg::*;
#(
  parameter int unsigned GRID_N  = GRID_N_DEF,
  parameter int unsigned CELL_PX = CELL_PX_DEF,
  parameter int unsigned X0      = X0_DEF,
  parameter int unsigned Y0      = Y0_DEF,
  parameter int unsigned FB_W    = FB_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [GRID_N-1:0]   col_select,
  input  logic [ROW_W-1:0]    row_select,
  input  logic [COLOR_W-1:0]  pixel_color,
  output logic [GRID_N-1:0]   return_sig,
  output logic [ADDR_W-1:0]   fb_address,
  output logic [COLOR_W-1:0]  fb_writedata,
  output logic                fb_write
);

  localparam logic [GRID_N-1:0] ONE_HOT0  = GRID_N'(1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(CELL_PX - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(FB_W - (CELL_PX - 1));

  state_t               state;
  logic [COL_W-1:0]     col_q;
  logic [ROW_W-1:0]     row_q;
  logic [COLOR_W-1:0]   color_q;
  logic [CNT_W-1:0]     col_cnt;
  logic [CNT_W-1:0]     line_cnt;

  logic [COL_W-1:0]     req_index;
  logic                 req_valid;
  logic [ADDR_W-1:0]    base_addr_c;
  logic [GRID_N-1:0]    ack_mask_c;

  onehot_priority_enc #(.N(GRID_N)) u_prio (
    .req   (col_select),
    .index (req_index),
    .valid (req_valid)
  );

  // Top-left pixel of the latched cell: (Y0 + row*CELL_PX)*FB_W + X0 + col*CELL_PX.
  assign base_addr_c = (ADDR_W'(Y0) + ADDR_W'(row_q) * ADDR_W'(CELL_PX)) * ADDR_W'(FB_W)
                     + ADDR_W'(X0) + ADDR_W'(col_q) * ADDR_W'(CELL_PX);
  assign ack_mask_c  = ONE_HOT0 << col_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      color_q      <= '0;
      col_cnt      <= '0;
      line_cnt     <= '0;
      return_sig   <= '0;
      fb_address   <= '0;
      fb_writedata <= '0;
      fb_write     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            col_q   <= req_index;
            row_q   <= row_select;
            color_q <= pixel_color;
            state   <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          col_cnt  <= '0;
          line_cnt <= '0;
          if (row_q < ROW_W'(GRID_N)) begin
            fb_address   <= base_addr_c;
            fb_writedata <= color_q;
            fb_write     <= 1'b1;
            state        <= ST_PAINT;
          end else begin
            return_sig <= ack_mask_c;
            state      <= ST_ACK;
          end
        end
        ST_PAINT: begin
          // Counters track the pixel currently on the bus; step to the next one.
          if (col_cnt == LAST_CNT) begin
            col_cnt <= '0;
            if (line_cnt == LAST_CNT) begin
              line_cnt   <= '0;
              fb_write   <= 1'b0;
              return_sig <= ack_mask_c;
              state      <= ST_ACK;
            end else begin
              line_cnt   <= line_cnt + CNT_W'(1);
              fb_address <= fb_address + LINE_STEP;
            end
          end else begin
            col_cnt    <= col_cnt + CNT_W'(1);
            fb_address <= fb_address + ADDR_W'(1);
          end
        end
        ST_ACK: begin
          // A request already withdrawn gets a single-cycle acknowledge.
          if (!col_select[col_q]) begin
            return_sig <= '0;
          end
          state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!col_select[col_q]) begin
            return_sig <= '0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_cell_painter.sv
// Directed bench for grid_cell_painter: addresses, latencies, handshake and reset behaviour.
module tb_grid_cell_painter;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] col_select;
  logic [9:0]  row_select;
  logic [7:0]  pixel_color;
  logic [63:0] return_sig;
  logic [18:0] fb_address;
  logic [7:0]  fb_writedata;
  logic        fb_write;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [18:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  int          wr_cyc[$];

  grid_cell_painter dut (
    .clock        (clock),
    .reset        (reset),
    .col_select   (col_select),
    .row_select   (row_select),
    .pixel_color  (pixel_color),
    .return_sig   (return_sig),
    .fb_address   (fb_address),
    .fb_writedata (fb_writedata),
    .fb_write     (fb_write)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Log every framebuffer write with the cycle it was presented in.
  always @(negedge clock) begin
    if (fb_write) begin
      wr_addr.push_back(fb_address);
      wr_data.push_back(fb_writedata);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int addr_at(input int idx);
    if (idx < wr_addr.size()) return int'(wr_addr[idx]);
    return -1;
  endfunction

  function automatic int cyc_at(input int idx);
    if (idx < wr_cyc.size()) return wr_cyc[idx];
    return -1;
  endfunction

  function automatic int bad_data(input int from, input logic [7:0] color);
    int bad = 0;
    for (int i = from; i < wr_data.size(); i++)
      if (wr_data[i] !== color) bad++;
    return bad;
  endfunction

  // Raise one column request (cycle n) and wait for its acknowledge (cycle rc).
  task automatic run_req(input int col, input logic [9:0] row, input logic [7:0] color,
                         input bit perturb, output int n, output int w0, output int rc);
    w0 = wr_addr.size();
    row_select = row;
    pixel_color = color;
    col_select[col] = 1'b1;
    n = cyc;
    rc = -1;
    for (int k = 0; k < 120; k++) begin
      @(negedge clock);
      if (perturb && k == 0) begin
        pixel_color = ~color;
        row_select = row ^ 10'h3;
      end
      if (return_sig[col]) begin
        rc = cyc;
        break;
      end
    end
    check($sformatf("ack_seen_c%0d", col), 64'(rc >= 0), 64'd1);
  endtask

  int n, w0, rc, n2, w2, rc2;

  initial begin
    reset = 1'b1;
    col_select = '0;
    row_select = '0;
    pixel_color = '0;
    repeat (2) @(negedge clock);
    check("rst_return", return_sig, 64'd0);
    check("rst_fb_write", 64'(fb_write), 64'd0);
    check("rst_fb_address", 64'(fb_address), 64'd0);
    check("rst_fb_writedata", 64'(fb_writedata), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Column 0, row 0: corner cell timing and address pattern.
    run_req(0, 10'd0, 8'hFF, 1'b0, n, w0, rc);
    check("c0_count", 64'(wr_addr.size() - w0), 64'd49);
    check("c0_addr1", 64'(addr_at(w0)), 64'd10336);
    check("c0_addr2", 64'(addr_at(w0 + 1)), 64'd10337);
    check("c0_addr8", 64'(addr_at(w0 + 7)), 64'd10976);
    check("c0_addr49", 64'(addr_at(w0 + 48)), 64'd14182);
    check("c0_first_lat", 64'(cyc_at(w0) - n), 64'd2);
    check("c0_last_lat", 64'(cyc_at(w0 + 48) - n), 64'd50);
    check("c0_ack_lat", 64'(rc - n), 64'd51);
    check("c0_return", return_sig, 64'h1);
    check("c0_data", 64'(bad_data(w0, 8'hFF)), 64'd0);
    col_select[0] = 1'b0;
    @(negedge clock);
    check("c0_release", return_sig, 64'd0);
    @(negedge clock);

    // Column 63, row 63 with inputs disturbed after capture.
    run_req(63, 10'd63, 8'h1C, 1'b1, n, w0, rc);
    check("c63_count", 64'(wr_addr.size() - w0), 64'd49);
    check("c63_first", 64'(addr_at(w0)), 64'd293017);
    check("c63_last", 64'(addr_at(w0 + 48)), 64'd296863);
    check("c63_return", return_sig, 64'h8000_0000_0000_0000);
    check("c63_data", 64'(bad_data(w0, 8'h1C)), 64'd0);
    col_select[63] = 1'b0;
    repeat (2) @(negedge clock);

    // Out-of-range row: acknowledge only, no writes.
    run_req(10, 10'd70, 8'h55, 1'b1, n, w0, rc);
    check("oor_ack_lat", 64'(rc - n), 64'd2);
    check("oor_writes", 64'(wr_addr.size() - w0), 64'd0);
    check("oor_return", return_sig, 64'h400);
    repeat (3) @(negedge clock);
    check("oor_hold", 64'(return_sig[10]), 64'd1);
    col_select[10] = 1'b0;
    @(negedge clock);
    check("oor_clear", return_sig, 64'd0);
    @(negedge clock);

    // Columns 5 and 9 together: 5 wins, 9 waits for its release.
    col_select[9] = 1'b1;
    run_req(5, 10'd0, 8'h33, 1'b0, n, w0, rc);
    check("pair5_return", return_sig, 64'h20);
    check("pair5_first", 64'(addr_at(w0)), 64'd10371);
    repeat (10) @(negedge clock);
    check("pair5_only", 64'(wr_addr.size() - w0), 64'd49);
    col_select[5] = 1'b0;
    run_req(9, 10'd0, 8'h44, 1'b0, n2, w2, rc2);
    check("pair9_count", 64'(wr_addr.size() - w2), 64'd49);
    check("pair9_first", 64'(addr_at(w2)), 64'd10399);
    check("pair9_start", 64'(cyc_at(w2) - n2), 64'd3);
    check("pair9_ack_lat", 64'(rc2 - n2), 64'd52);
    check("pair9_return", return_sig, 64'h200);
    col_select[9] = 1'b0;
    repeat (2) @(negedge clock);

    // Reset asserted while the 20th pixel is on the bus.
    w0 = wr_addr.size();
    row_select = 10'd2;
    pixel_color = 8'h5A;
    col_select[1] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      #1;
      if (wr_addr.size() - w0 >= 20) break;
    end
    check("rst_reach20", 64'(wr_addr.size() - w0), 64'd20);
    reset = 1'b1;
    #1;
    check("rst_mid_write", 64'(fb_write), 64'd0);
    check("rst_mid_return", return_sig, 64'd0);
    col_select = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (60) @(negedge clock);
    check("rst_no_more", 64'(wr_addr.size() - w0), 64'd20);
    check("rst_no_ack", return_sig, 64'd0);

    // Column 3 held long after acknowledge: painted only once.
    run_req(3, 10'd5, 8'h77, 1'b0, n, w0, rc);
    check("hold_count", 64'(wr_addr.size() - w0), 64'd49);
    repeat (200) @(negedge clock);
    check("hold_once", 64'(wr_addr.size() - w0), 64'd49);
    check("hold_return", return_sig, 64'h8);
    col_select[3] = 1'b0;
    @(negedge clock);
    check("hold_clear", return_sig, 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/grid_cell_painter.md
GRID_CELL_PAINTER -- requirements
Module: grid_cell_painter

Interface
REQ-001 Parameter GRID_N, default 64: number of grid columns and rows.
REQ-002 Parameter CELL_PX, default 7: screen pixels per grid cell edge.
REQ-003 Parameter X0, default 96: screen x of grid column 0.
REQ-004 Parameter Y0, default 16: screen y of grid row 0.
REQ-005 Parameter FB_W, default 640: framebuffer line pitch in pixels.
REQ-006 Port clock, input, 1: single clock for the whole block.
REQ-007 Port reset, input, 1: asynchronous, active-high reset.
REQ-008 Port col_select, input, GRID_N: one request bit per column, from the upstream plotter.
REQ-009 Port row_select, input, 10: grid row of the request.
REQ-010 Port pixel_color, input, 8: colour of the request.
REQ-011 Port return_sig, output, GRID_N: one acknowledge bit per column.
REQ-012 Port fb_address, output, 19: framebuffer word address, y*FB_W+x.
REQ-013 Port fb_writedata, output, 8: pixel colour to write.
REQ-014 Port fb_write, output, 1: framebuffer write strobe, one pixel per cycle.

Function
REQ-015 The FSM SHALL have five states: IDLE, LATCH, PAINT, ACK and RELEASE.
REQ-016 IDLE: when any col_select bit is high, the block SHALL select the lowest set index, register it with row_select and pixel_color, and enter LATCH; other requests wait.
REQ-017 LATCH: if the row is below GRID_N, the block SHALL compute base = (Y0+row*CELL_PX)*FB_W + X0+col*CELL_PX and enter PAINT; otherwise it SHALL enter ACK without any write.
REQ-018 PAINT: the block SHALL assert fb_write for exactly CELL_PX*CELL_PX consecutive cycles.
REQ-019 PAINT address sequence: fb_writedata holds the latched colour; the address increments by 1 within a cell line and by FB_W-(CELL_PX-1) at the end of each line.
REQ-020 PAINT SHALL use a 3-bit column counter and a 3-bit line counter; after the last write it SHALL enter ACK.
REQ-021 ACK: the block SHALL set return_sig[col]=1, with all other return_sig bits 0, and enter RELEASE.
REQ-022 RELEASE: return_sig[col] SHALL stay high until col_select[col]=0; the block SHALL then clear it and return to IDLE.
REQ-023 A held col_select SHALL NOT trigger a second paint.
REQ-024 Latency for a valid request (first request cycle = N): first write at N+2, last write at N+50, return_sig high at N+51.
REQ-025 Out-of-range row: return_sig SHALL be high at N+2 with no writes.
REQ-026 Input changes after capture SHALL be ignored until the next IDLE.
REQ-027 If col_select[col] drops during PAINT, painting SHALL still complete, then ACK pulses for one cycle and RELEASE exits at once.
REQ-028 All arithmetic SHALL be unsigned, with no overflow for in-range coordinates (maximum address 296863 < 2^19).

Reset
REQ-029 Reset SHALL be asynchronous: state IDLE; return_sig, fb_address, fb_writedata, fb_write and all counters 0.
REQ-030 Reset mid-PAINT SHALL drop fb_write immediately, discard the request, and leave no pending acknowledge.

Structure
REQ-031 GRID_N, CELL_PX, X0, Y0, FB_W and the FSM state encoding SHALL live in a shared package.
REQ-032 Lowest-index selection SHALL be a sub-module, onehot_priority_enc (GRID_N in, 6-bit index plus valid out).
REQ-033 The FSM, counters and address datapath SHALL reside in grid_cell_painter.

Verification
REQ-034 col 0, row 0, colour 0xFF -> 49 writes; first address 10336, second 10337, eighth 10976; return_sig[0] at N+51.
REQ-035 col 63, row 63, colour 0x1C -> first address 293017, last address 296863; return_sig[63] only.
REQ-036 col 10, row 70 -> no fb_write; return_sig[10] at N+2; it clears one cycle after col_select[10] falls.
REQ-037 col_select bits 5 and 9 together -> column 5 painted and acknowledged first; column 9 starts after bit 5 is released.
REQ-038 reset asserted at the 20th write -> fb_write and return_sig 0 the same cycle; no further writes after release.
REQ-039 col_select[3] held 200 cycles after acknowledge -> exactly 49 writes total.
